// File: rtl/lsu.sv
// rtl/lsu.sv - load/store stage: one word-aligned memory access per instruction, bypass for non-memory ops
module lsu #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              lsu_receive_valid,
  output logic              lsu_receive_ready,
  input  logic [DATA_W-1:0] alu_result,
  input  logic [DATA_W-1:0] rsb,
  input  logic              ren,
  input  logic              wen,
  input  logic [7:0]        wmask,
  input  logic [DATA_W-1:0] rmask,
  input  logic              memory_read_signed,
  input  logic              reg_write_en,
  input  logic [4:0]        rd,
  input  logic [31:0]       pc,
  input  logic [31:0]       instruction,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_wen,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [3:0]        mem_wstrb,
  input  logic              mem_resp_valid,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              lsu_send_valid,
  input  logic              lsu_send_ready,
  output logic [DATA_W-1:0] lsu_result,
  output logic              reg_write_en_o,
  output logic [4:0]        rd_o,
  output logic [31:0]       pc_o,
  output logic [31:0]       instruction_o
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  state_t state, state_nxt;

  logic [DATA_W-1:0] alu_q;
  logic [DATA_W-1:0] rsb_q;
  logic [DATA_W-1:0] rmask_q;
  logic [3:0]        wmask_q;
  logic              load_q;
  logic              store_q;
  logic              signed_q;

  logic              accept;
  logic              mem_op;
  logic [4:0]        shamt;
  logic [DATA_W-1:0] shifted;
  logic [DATA_W-1:0] masked;
  logic [DATA_W-1:0] load_data;
  logic              unused_wmask_hi;

  assign accept = (state == IDLE) && lsu_receive_valid;
  assign mem_op = ren | wen;
  assign shamt  = {alu_q[1:0], 3'b000};
  assign unused_wmask_hi = ^wmask[7:4];

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (lsu_receive_valid) state_nxt = mem_op ? REQ : DONE;
      REQ:  if (mem_req_ready)     state_nxt = WAIT;
      WAIT: if (mem_resp_valid)    state_nxt = DONE;
      DONE: if (lsu_send_ready)    state_nxt = IDLE;
      default:                     state_nxt = IDLE;
    endcase
  end

  // Load alignment: bring the addressed byte lane down to bit 0, mask, then extend.
  assign shifted = mem_rdata >> shamt;
  assign masked  = shifted & rmask_q;

  always_comb begin
    load_data = masked;
    if (signed_q) begin
      if (rmask_q == 32'h0000_00FF)      load_data = {{24{masked[7]}}, masked[7:0]};
      else if (rmask_q == 32'h0000_FFFF) load_data = {{16{masked[15]}}, masked[15:0]};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      alu_q          <= '0;
      rsb_q          <= '0;
      rmask_q        <= '0;
      wmask_q        <= '0;
      load_q         <= 1'b0;
      store_q        <= 1'b0;
      signed_q       <= 1'b0;
      lsu_result     <= '0;
      reg_write_en_o <= 1'b0;
      rd_o           <= '0;
      pc_o           <= '0;
      instruction_o  <= '0;
    end else begin
      if (accept) begin
        alu_q          <= alu_result;
        rsb_q          <= rsb;
        rmask_q        <= rmask;
        wmask_q        <= wmask[3:0];
        store_q        <= wen;
        load_q         <= ren & ~wen;
        signed_q       <= memory_read_signed;
        reg_write_en_o <= reg_write_en;
        rd_o           <= rd;
        pc_o           <= pc;
        instruction_o  <= instruction;
        if (!mem_op) lsu_result <= alu_result;
      end
      if (state == WAIT && mem_resp_valid)
        lsu_result <= load_q ? load_data : alu_q;
    end
  end

  // Strobes shifted past lane 3 fall off the 4-bit result; cross-word accesses are not split.
  assign mem_addr          = {alu_q[ADDR_W-1:2], 2'b00};
  assign mem_wen           = store_q;
  assign mem_wdata         = rsb_q << shamt;
  assign mem_wstrb         = wmask_q << alu_q[1:0];
  assign mem_req_valid     = (state == REQ);
  assign lsu_send_valid    = (state == DONE);
  assign lsu_receive_ready = (state == IDLE);

endmodule

// File: tb/tb_lsu.sv
// tb/tb_lsu.sv - directed self-checking bench for lsu
module tb_lsu;

  logic        clk = 1'b0;
  logic        rst;
  logic        lsu_receive_valid;
  logic        lsu_receive_ready;
  logic [31:0] alu_result;
  logic [31:0] rsb;
  logic        ren;
  logic        wen;
  logic [7:0]  wmask;
  logic [31:0] rmask;
  logic        memory_read_signed;
  logic        reg_write_en;
  logic [4:0]  rd;
  logic [31:0] pc;
  logic [31:0] instruction;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [31:0] mem_addr;
  logic        mem_wen;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_resp_valid;
  logic [31:0] mem_rdata;
  logic        lsu_send_valid;
  logic        lsu_send_ready;
  logic [31:0] lsu_result;
  logic        reg_write_en_o;
  logic [4:0]  rd_o;
  logic [31:0] pc_o;
  logic [31:0] instruction_o;

  int checks = 0;
  int errors = 0;

  lsu dut (
    .clk(clk), .rst(rst),
    .lsu_receive_valid(lsu_receive_valid), .lsu_receive_ready(lsu_receive_ready),
    .alu_result(alu_result), .rsb(rsb), .ren(ren), .wen(wen),
    .wmask(wmask), .rmask(rmask), .memory_read_signed(memory_read_signed),
    .reg_write_en(reg_write_en), .rd(rd), .pc(pc), .instruction(instruction),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_addr(mem_addr), .mem_wen(mem_wen), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_resp_valid(mem_resp_valid), .mem_rdata(mem_rdata),
    .lsu_send_valid(lsu_send_valid), .lsu_send_ready(lsu_send_ready),
    .lsu_result(lsu_result),
    .reg_write_en_o(reg_write_en_o), .rd_o(rd_o), .pc_o(pc_o), .instruction_o(instruction_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance one edge; inputs change and outputs are sampled 1ns later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic present(input logic [31:0] a, input logic [31:0] d, input logic r, input logic w,
                         input logic [7:0] wm, input logic [31:0] rm, input logic sg);
    alu_result = a; rsb = d; ren = r; wen = w; wmask = wm; rmask = rm;
    memory_read_signed = sg; lsu_receive_valid = 1'b1;
  endtask

  // Runs one load from accept to result; leaves the DUT in DONE.
  task automatic do_load(input string tag, input logic [31:0] a, input logic [31:0] rm,
                         input logic sg, input logic [31:0] rdata,
                         input logic [31:0] exp_addr, input logic [31:0] exp_res);
    present(a, 32'h0, 1'b1, 1'b0, 8'h0, rm, sg);
    mem_req_ready = 1'b1;
    tick();
    lsu_receive_valid = 1'b0;
    check({tag, "_req_valid"}, {31'b0, mem_req_valid}, 32'd1);
    check({tag, "_addr"}, mem_addr, exp_addr);
    check({tag, "_wen"}, {31'b0, mem_wen}, 32'd0);
    tick();
    check({tag, "_wait_send"}, {31'b0, lsu_send_valid}, 32'd0);
    mem_resp_valid = 1'b1;
    mem_rdata = rdata;
    tick();
    mem_resp_valid = 1'b0;
    check({tag, "_send_valid"}, {31'b0, lsu_send_valid}, 32'd1);
    check({tag, "_result"}, lsu_result, exp_res);
  endtask

  task automatic retire(input string tag);
    lsu_send_ready = 1'b1;
    tick();
    lsu_send_ready = 1'b0;
    check({tag, "_idle_ready"}, {31'b0, lsu_receive_ready}, 32'd1);
    check({tag, "_idle_send"}, {31'b0, lsu_send_valid}, 32'd0);
  endtask

  initial begin
    rst = 1'b0; lsu_receive_valid = 1'b0;
    alu_result = '0; rsb = '0; ren = 1'b0; wen = 1'b0; wmask = '0; rmask = '0;
    memory_read_signed = 1'b0; reg_write_en = 1'b0; rd = '0; pc = '0; instruction = '0;
    mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_rdata = '0; lsu_send_ready = 1'b0;
    tick();
    tick();
    check("rst_req_valid", {31'b0, mem_req_valid}, 32'd0);
    check("rst_send_valid", {31'b0, lsu_send_valid}, 32'd0);
    check("rst_result", lsu_result, 32'h0);
    check("rst_pc_o", pc_o, 32'h0);
    rst = 1'b1;
    tick();
    check("rst_recv_ready", {31'b0, lsu_receive_ready}, 32'd1);

    // Non-memory bypass with pass-through fields
    present(32'h0000_1234, 32'h0, 1'b0, 1'b0, 8'h0, 32'h0, 1'b0);
    reg_write_en = 1'b1; rd = 5'd7; pc = 32'h8000_0100; instruction = 32'h0000_0013;
    lsu_send_ready = 1'b1;
    tick();
    lsu_receive_valid = 1'b0;
    check("nm_send_valid", {31'b0, lsu_send_valid}, 32'd1);
    check("nm_result", lsu_result, 32'h0000_1234);
    check("nm_req_valid", {31'b0, mem_req_valid}, 32'd0);
    check("nm_recv_ready", {31'b0, lsu_receive_ready}, 32'd0);
    check("nm_rd_o", {27'b0, rd_o}, 32'd7);
    check("nm_pc_o", pc_o, 32'h8000_0100);
    check("nm_instr_o", instruction_o, 32'h0000_0013);
    check("nm_rwe_o", {31'b0, reg_write_en_o}, 32'd1);
    tick();
    lsu_send_ready = 1'b0;
    check("nm_idle_ready", {31'b0, lsu_receive_ready}, 32'd1);

    do_load("lb", 32'h8000_0003, 32'h0000_00FF, 1'b1, 32'h80FF_FFFF, 32'h8000_0000, 32'hFFFF_FF80);
    retire("lb");
    do_load("lhu", 32'h8000_0002, 32'h0000_FFFF, 1'b0, 32'hBEEF_1234, 32'h8000_0000, 32'h0000_BEEF);
    retire("lhu");
    do_load("lh", 32'h8000_0002, 32'h0000_FFFF, 1'b1, 32'hBEEF_1234, 32'h8000_0000, 32'hFFFF_BEEF);
    retire("lh");
    do_load("lw", 32'h8000_0004, 32'hFFFF_FFFF, 1'b1, 32'h8765_4321, 32'h8000_0004, 32'h8765_4321);
    retire("lw");
    do_load("lbu", 32'h8000_0001, 32'h0000_00FF, 1'b0, 32'h1122_F344, 32'h8000_0000, 32'h0000_00F3);
    retire("lbu");

    // Byte store
    present(32'h8000_0001, 32'h0000_00AB, 1'b0, 1'b1, 8'h01, 32'h0, 1'b0);
    mem_req_ready = 1'b1;
    tick();
    lsu_receive_valid = 1'b0;
    check("sb_req_valid", {31'b0, mem_req_valid}, 32'd1);
    check("sb_wen", {31'b0, mem_wen}, 32'd1);
    check("sb_wstrb", {28'b0, mem_wstrb}, 32'h2);
    check("sb_wdata", mem_wdata, 32'h0000_AB00);
    check("sb_addr", mem_addr, 32'h8000_0000);
    tick();
    check("sb_wait_send", {31'b0, lsu_send_valid}, 32'd0);
    mem_resp_valid = 1'b1;
    tick();
    mem_resp_valid = 1'b0;
    check("sb_send_valid", {31'b0, lsu_send_valid}, 32'd1);
    check("sb_result", lsu_result, 32'h8000_0001);
    retire("sb");

    // Half store crossing the word: only lane 3 is kept
    present(32'h8000_0003, 32'h0000_CAFE, 1'b0, 1'b1, 8'h03, 32'h0, 1'b0);
    tick();
    lsu_receive_valid = 1'b0;
    check("mis_wstrb", {28'b0, mem_wstrb}, 32'h8);
    check("mis_wdata", mem_wdata, 32'hFE00_0000);
    tick();
    mem_resp_valid = 1'b1;
    tick();
    mem_resp_valid = 1'b0;
    retire("mis");

    // Backpressure; ren and wen both set so the store wins
    present(32'h8000_0012, 32'h0000_CAFE, 1'b1, 1'b1, 8'h03, 32'h0000_FFFF, 1'b1);
    mem_req_ready = 1'b0;
    tick();
    lsu_receive_valid = 1'b0;
    alu_result = 32'hDEAD_BEEF; rsb = 32'h5555_5555; wmask = 8'h0F;
    mem_resp_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check("bp_req_valid", {31'b0, mem_req_valid}, 32'd1);
      check("bp_addr", mem_addr, 32'h8000_0010);
      check("bp_wen", {31'b0, mem_wen}, 32'd1);
      check("bp_wdata", mem_wdata, 32'hCAFE_0000);
      check("bp_wstrb", {28'b0, mem_wstrb}, 32'hC);
      check("bp_recv_ready", {31'b0, lsu_receive_ready}, 32'd0);
      tick();
      mem_resp_valid = 1'b0;
    end
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      check("bp_wait_req", {31'b0, mem_req_valid}, 32'd0);
      check("bp_wait_send", {31'b0, lsu_send_valid}, 32'd0);
      check("bp_wait_ready", {31'b0, lsu_receive_ready}, 32'd0);
      tick();
    end
    mem_resp_valid = 1'b1;
    mem_rdata = 32'hFFFF_FFFF;
    tick();
    mem_resp_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      check("bp_done_valid", {31'b0, lsu_send_valid}, 32'd1);
      check("bp_done_result", lsu_result, 32'h8000_0012);
      check("bp_done_ready", {31'b0, lsu_receive_ready}, 32'd0);
      tick();
    end
    retire("bp");

    // Reset while waiting for the response
    present(32'h8000_0020, 32'h0, 1'b1, 1'b0, 8'h0, 32'hFFFF_FFFF, 1'b0);
    mem_req_ready = 1'b1;
    tick();
    lsu_receive_valid = 1'b0;
    tick();
    check("rw_in_wait", {31'b0, mem_req_valid | lsu_send_valid}, 32'd0);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    check("rw_recv_ready", {31'b0, lsu_receive_ready}, 32'd1);
    check("rw_addr", mem_addr, 32'h0);
    mem_resp_valid = 1'b1;
    mem_rdata = 32'h1234_5678;
    tick();
    mem_resp_valid = 1'b0;
    check("rw_send_valid", {31'b0, lsu_send_valid}, 32'd0);
    check("rw_result", lsu_result, 32'h0);
    tick();
    check("rw_send_valid2", {31'b0, lsu_send_valid}, 32'd0);
    check("rw_req_valid", {31'b0, mem_req_valid}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/lsu.md
# lsu

Load/store stage directly downstream of the execute stage. Captures one executed instruction per handshake; for loads/stores it issues a single word-aligned request on the data-memory port, waits for the response, aligns/masks/sign-extends load data, and forwards the result with control fields to writeback. Non-memory instructions bypass the bus with one-cycle latency.

## Interface
Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width (fixed 32; not otherwise supported)

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-low (asserted when 0)
- lsu_receive_valid  in  1  execute stage has an instruction
- lsu_receive_ready  out  1  lsu can accept (high only in IDLE)
- alu_result  in  32  effective address, or result for non-memory ops
- rsb  in  32  store data (unaligned, low bytes significant)
- ren / wen  in  1 / 1  load / store
- wmask  in  8  store byte mask, bits [3:0] used (0x1/0x3/0xF)
- rmask  in  32  load mask (0xFF/0xFFFF/0xFFFFFFFF)
- memory_read_signed  in  1  sign-extend load
- reg_write_en, rd, pc, instruction  in  1/5/32/32  pass-through
- mem_req_valid  out  1  bus request
- mem_req_ready  in  1  bus accepts request
- mem_addr  out  32  {alu_result[31:2], 2'b00}
- mem_wen  out  1  request is write
- mem_wdata  out  32  rsb << 8*addr[1:0]
- mem_wstrb  out  4  wmask[3:0] << addr[1:0]
- mem_resp_valid  in  1  response (read data or write ack)
- mem_rdata  in  32  read data
- lsu_send_valid  out  1  result available to writeback
- lsu_send_ready  in  1  writeback accepts
- lsu_result  out  32  load data or captured alu_result
- reg_write_en_o, rd_o, pc_o, instruction_o  out  registered pass-through

## Operation
- States: IDLE, REQ, WAIT, DONE.
- IDLE: receive_ready=1. On receive_valid: capture all inputs; if ren|wen -> REQ else lsu_result<=alu_result, -> DONE.
- ren and wen both set: treat as store (wen wins).
- REQ: mem_req_valid=1, addr/wen/wdata/wstrb stable from captured regs. On mem_req_ready -> WAIT.
- WAIT: mem_resp_valid ignored outside WAIT. On mem_resp_valid: load -> lsu_result = sext/zext((mem_rdata >> 8*addr[1:0]) & rmask); sign bit is bit 7 for rmask 0xFF, bit 15 for 0xFFFF, none for full word; store -> lsu_result = captured alu_result. -> DONE.
- DONE: lsu_send_valid=1, outputs stable. On lsu_send_ready -> IDLE.
- Misaligned accesses crossing a word: not detected; only bytes inside the aligned word are accessed (shifted strobes beyond bit 3 are dropped).
- No back-to-back: a new instruction is accepted only in IDLE, one cycle after send handshake.

## Timing
- Reset (rst=0 at clk edge): state IDLE; all registered outputs 0; mem_req_valid=0, lsu_send_valid=0; lsu_receive_ready=1 after reset releases. Reset mid-transaction aborts it; outstanding mem response afterwards is ignored (state IDLE).
- Non-memory latency: accept at edge N, lsu_send_valid high from N+1.
- Memory latency: accept at N, mem_req_valid from N+1; req accepted at edge M, response at edge R>M, lsu_send_valid from R+1.
- mem_req_valid held until mem_req_ready; request fields unchanged while held.
- lsu_send_valid held with stable data until lsu_send_ready.
- All outputs registered or decoded from state only; no combinational path from mem_* or lsu_send_ready to outputs except state change next edge.

## Test plan
- Non-memory: alu_result=0x1234, ren=wen=0, send_ready=1 -> lsu_send_valid next cycle, lsu_result=0x1234, no mem_req_valid.
- Signed byte load: addr=0x80000003, rmask=0xFF, signed=1, mem_rdata=0x80FFFFFF -> mem_addr=0x80000000, lsu_result=0xFFFFFF80.
- Unsigned half load: addr=0x80000002, rmask=0xFFFF, signed=0, mem_rdata=0xBEEF1234 -> lsu_result=0x0000BEEF.
- Byte store: addr=0x80000001, rsb=0x000000AB, wmask=0x1 -> mem_wen=1, mem_wstrb=0x2, mem_wdata=0x0000AB00; lsu_send_valid after ack.
- Backpressure: mem_req_ready low 3 cycles, mem_resp_valid after 2 more, lsu_send_ready low 2 cycles -> request fields and result stable throughout; receive_ready=0 until IDLE.
- Reset in WAIT: rst=0 one cycle, then late mem_resp_valid -> state IDLE, lsu_send_valid stays 0.
